alu_share_ctrl: RTL and testbench

- Sequencer/arbiter that shares one combinational 8-bit ALU between two requesters.
- The ALU has a 4-bit ctrl, x, y, carry and out; its ctrl encoding is 0000 add through 1100 equal.
- Each requester issues ctrl/x/y with a valid/ready handshake. The block arbitrates round-robin, drives registered operands into the ALU, captures out/carry, and returns a tagged response with valid/ready back-pressure.
- Sits between the issuing units and the ALU instance; the ALU stays purely combinational outside this block.

---
 rtl/alu_share_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional opcode range check is enabled with `define ALU_OPCHK_EN.
module alu_share_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CTRL_W  = 4,
  parameter int LAST_OP = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_out,
  output logic              resp_carry,
  output logic              resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_rst_sync;
  logic              r_rr_ptr;
  logic              r_id;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [DATA_W-1:0] r_alu_x, r_alu_y, r_resp_out;
  logic              r_resp_valid, r_resp_carry;
  logic              w_run, w_gnt1, w_hs, w_bad;
  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_x, w_y;

  // Reset is released to the FSM two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};

  assign w_run  = r_rst_sync[1];
  assign w_gnt1 = req1_valid & (~req0_valid | r_rr_ptr);
  assign w_hs   = (r_state == S_IDLE) & w_run & (req0_valid | req1_valid);
  assign w_ctrl = w_gnt1 ? req1_ctrl : req0_ctrl;
  assign w_x    = w_gnt1 ? req1_x    : req0_x;
  assign w_y    = w_gnt1 ? req1_y    : req0_y;

`ifdef ALU_OPCHK_EN
  logic r_resp_err;
  assign w_bad    = int'(w_ctrl) > LAST_OP;
  assign resp_err = r_resp_err;
`else
  assign w_bad    = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = w_bad ? S_RESP : S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_hs & ~w_gnt1;
    req1_ready = w_hs &  w_gnt1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= 1'b0;
      r_id         <= 1'b0;
      r_alu_ctrl   <= '0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_out   <= '0;
      r_resp_carry <= 1'b0;
`ifdef ALU_OPCHK_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_hs) begin
          r_id     <= w_gnt1;
          r_rr_ptr <= ~w_gnt1;
          if (!w_bad) begin
            r_alu_ctrl <= w_ctrl;
            r_alu_x    <= w_x;
            r_alu_y    <= w_y;
          end
`ifdef ALU_OPCHK_EN
          else begin
            // Illegal op never reaches the ALU; answer directly with an error.
            r_resp_valid <= 1'b1;
            r_resp_out   <= '0;
            r_resp_carry <= 1'b0;
            r_resp_err   <= 1'b1;
          end
`endif
        end
        S_EXEC: begin
          r_resp_valid <= 1'b1;
          r_resp_out   <= alu_out;
          r_resp_carry <= alu_carry;
`ifdef ALU_OPCHK_EN
          r_resp_err   <= 1'b0;
`endif
        end
        S_RESP: if (resp_ready) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign alu_ctrl   = r_alu_ctrl;
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_out   = r_resp_out;
  assign resp_carry = r_resp_carry;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: bench-side ALU, cycle-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_share_ctrl;
  localparam int DW = 8;
  localparam int CW = 4;

  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] x, y; } op_t;
  typedef struct packed { logic id; logic [DW-1:0] out; logic carry, err; } rsp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    v = '0;
  logic [CW-1:0] c [2] = '{default: '0};
  logic [DW-1:0] x [2] = '{default: '0};
  logic [DW-1:0] y [2] = '{default: '0};
  logic          rdy0, rdy1;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_x, alu_y, alu_out, resp_out;
  logic          alu_carry, resp_ready = 1'b1, resp_valid, resp_id, resp_carry, resp_err;

  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_ctrl(c[0]), .req0_x(x[0]), .req0_y(y[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_ctrl(c[1]), .req1_x(x[1]), .req1_y(y[1]),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out), .alu_carry(alu_carry),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_carry(resp_carry), .resp_err(resp_err)
  );

  // Bench ALU: {carry, out}; 0000 add .. 1100 equal, undefined codes give {1, ~a}.
  function automatic logic [DW:0] alu_fn(logic [CW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      4'd0:  return {1'b0, a} + {1'b0, b};
      4'd1:  return {1'b0, a} - {1'b0, b};
      4'd2:  return {1'b0, a & b};
      4'd3:  return {1'b0, a | b};
      4'd4:  return {1'b0, a ^ b};
      4'd5:  return {1'b0, ~a};
      4'd6:  return {a, 1'b0};
      4'd7:  return {a[0], 1'b0, a[DW-1:1]};
      4'd8:  return {1'b0, a[DW-2:0], a[DW-1]};
      4'd9:  return {1'b0, a[0], a[DW-1:1]};
      4'd10: return {1'b0, a} + 9'd1;
      4'd11: return {1'b0, a} - 9'd1;
      4'd12: return {1'b0, 7'd0, a == b};
      default: return {1'b1, ~a};
    endcase
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Requesters: each presents the head of its queue and holds it until accepted.
  op_t        q [2][$];
  logic [1:0] acc = '0;
  bit         drop_en = 0, gap_en = 0;

  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i] || (v[i] && drop_en && $urandom_range(0, 19) == 0)) begin
        void'(q[i].pop_front());
        v[i] = 1'b0;
      end
      if (!v[i] && q[i].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        v[i] = 1'b1; c[i] = q[i][0].c; x[i] = q[i][0].x; y[i] = q[i][0].y;
      end
    end
  end

  // Reference model: at most one op in flight; free, issuing, or holding a response.
  op_t  m_alu;
  rsp_t m_rsp;
  bit   m_busy, m_rv, m_ptr, m_fresh;
  int   m_hold, m_win;
  rsp_t log_q[$];

  always @(negedge clk) begin
    acc = {v[1] & rdy1, v[0] & rdy0};
    if (!rst_n) begin
      m_busy = 0; m_rv = 0; m_ptr = 0; m_fresh = 1; m_hold = 2;
      m_alu = '0; m_rsp = '0;
    end
    m_win = -1;
    if (rst_n && m_hold == 0 && !m_busy) begin
      if (v[0] && v[1]) m_win = int'(m_ptr);
      else if (v[0])    m_win = 0;
      else if (v[1])    m_win = 1;
    end
    chk("req0_ready", rdy0, m_win == 0);
    chk("req1_ready", rdy1, m_win == 1);
    chk("alu_ctrl", alu_ctrl, m_alu.c);
    chk("alu_x", alu_x, m_alu.x);
    chk("alu_y", alu_y, m_alu.y);
    chk("resp_valid", resp_valid, m_rv);
    if (m_rv || m_fresh) begin
      chk("resp_id", resp_id, m_rsp.id);
      chk("resp_out", resp_out, m_rsp.out);
      chk("resp_carry", resp_carry, m_rsp.carry);
      chk("resp_err", resp_err, m_rsp.err);
    end
    if (resp_valid && resp_ready) log_q.push_back('{resp_id, resp_out, resp_carry, resp_err});
    if (rst_n) begin
      if (m_hold > 0) m_hold--;
      else if (m_rv) begin
        if (resp_ready) begin m_rv = 0; m_busy = 0; end
      end else if (m_busy) m_rv = 1;
      else if (m_win >= 0) begin
        m_busy = 1; m_fresh = 0; m_ptr = (m_win == 0);
`ifdef ALU_OPCHK_EN
        if (c[m_win] > 4'd12) begin
          m_rsp = '{m_win[0], '0, 1'b0, 1'b1};
          m_rv  = 1;
        end else
`endif
        begin
          m_alu = '{c[m_win], x[m_win], y[m_win]};
          m_rsp = '{m_win[0], alu_fn(c[m_win], x[m_win], y[m_win]) & 9'h0FF,
                    alu_fn(c[m_win], x[m_win], y[m_win]) >> 8, 1'b0};
        end
      end
    end
  end

  task automatic wait_log(int n, int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin @(negedge clk); k++; end
    if (log_q.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_log responses=%0d required=%0d", log_q.size(), n);
      while (log_q.size() < n) log_q.push_back('0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    log_q.delete();
  endtask

  task automatic chk_rsp(string nm, int i, logic id, logic [DW-1:0] out, logic carry);
    chk({nm, "_id"}, log_q[i].id, id);
    chk({nm, "_out"}, log_q[i].out, out);
    chk({nm, "_carry"}, log_q[i].carry, carry);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single op: FF + 01
    q[0].push_back('{4'd0, 8'hFF, 8'h01});
    wait_log(1, 20);
    chk_rsp("single", 0, 1'b0, 8'h00, 1'b1);
    chk("single_err", log_q[0].err, 0);

    // Simultaneous requests; req0 re-presents at once, so the next contention goes to req1
    do_reset();
    q[0].push_back('{4'd1, 8'h00, 8'h01});
    q[0].push_back('{4'd1, 8'h00, 8'h01});
    q[1].push_back('{4'd2, 8'h05, 8'h03});
    wait_log(3, 40);
    chk_rsp("both_a", 0, 1'b0, 8'hFF, 1'b1);
    chk_rsp("both_b", 1, 1'b1, 8'h01, 1'b0);
    chk_rsp("both_c", 2, 1'b0, 8'hFF, 1'b1);

    // Back-pressure with rotate-left
    log_q.delete();
    resp_ready = 1'b0;
    q[0].push_back('{4'd8, 8'hC0, 8'h00});
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    q[1].push_back('{4'd0, 8'h01, 8'h01});
    repeat (5) begin
      @(negedge clk);
      chk("bp_out", resp_out, 8'h81);
      chk("bp_rdy1", rdy1, 0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_log(2, 20);
    chk_rsp("bp_a", 0, 1'b0, 8'h81, 1'b0);
    chk_rsp("bp_b", 1, 1'b1, 8'h02, 1'b0);

    // Fairness: equal ops, both continuously valid
    do_reset();
    repeat (3) begin
      q[0].push_back('{4'd12, 8'hFF, 8'hFF});
      q[1].push_back('{4'd12, 8'hFF, 8'hFF});
    end
    wait_log(6, 60);
    for (int k = 0; k < 6; k++) chk_rsp("fair", k, k[0], 8'h01, 1'b0);

    // Reset during EXEC
    log_q.delete();
    q[0].push_back('{4'd0, 8'h01, 8'h01});
    n = 0;
    do begin @(negedge clk); n++; end while (!(v[0] && rdy0) && n < 20);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_resp", log_q.size(), 0);
    q[0].push_back('{4'd4, 8'h0F, 8'hF0});
    q[1].push_back('{4'd3, 8'h0F, 8'hF0});
    wait_log(2, 30);
    chk_rsp("rst_after", 0, 1'b0, 8'hFF, 1'b0);

    // Opcode 1110 from requester 1
    log_q.delete();
    q[1].push_back('{4'd14, 8'h33, 8'h11});
    n = 0;
    do begin @(negedge clk); n++; end while (!(v[1] && rdy1) && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 10);
    wait_log(1, 20);
`ifdef ALU_OPCHK_EN
    chk("opchk_lat", n, 1);
    chk_rsp("opchk", 0, 1'b1, 8'h00, 1'b0);
    chk("opchk_err", log_q[0].err, 1);
`else
    chk("opchk_lat", n, 2);
    chk_rsp("opchk", 0, 1'b1, 8'hCC, 1'b1);
    chk("opchk_err", log_q[0].err, 0);
`endif

    // Randomized traffic, random back-pressure, occasional reset pulses
    drop_en = 1; gap_en = 1;
    repeat (1500) begin
      @(posedge clk); #1;
      resp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 2; i++)
        if (q[i].size() < 3)
          q[i].push_back('{4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom)});
    end
    rst_n = 1'b1; resp_ready = 1'b1; drop_en = 0;
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
